// File: rtl/redux_ctrl.sv
// 2x2 image reduction sequencer: reads four source pixels per block from a
// synchronous RAM, averages them (truncating) and writes one destination pixel.
module redux_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int RD_AW = 6,
  parameter int WR_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [RD_AW-1:0] rd_addr_o,
  input  logic [7:0]       rd_data_i,
  output logic             wr_en_o,
  output logic [WR_AW-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic             wr_ready_i
);
  localparam int BW = (IMG_W/2 > 1) ? $clog2(IMG_W/2) : 1;
  localparam int BH = (IMG_H/2 > 1) ? $clog2(IMG_H/2) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_WRITE, S_DONE} state_t;

  state_t          state_q;
  logic [1:0]      k_q;
  logic [BW-1:0]   bcol_q;
  logic [BH-1:0]   brow_q;
  logic [9:0]      sum_q;
  logic            busy_q, done_q, rd_en_q, wr_en_q;
  logic [RD_AW-1:0] rd_addr_q;
  logic [WR_AW-1:0] wr_addr_q;
  logic [7:0]      wr_data_q;

  logic            bcol_wrap, last_blk;
  logic [BW-1:0]   bcol_d;
  logic [BH-1:0]   brow_d;
  logic [9:0]      sum_d;

  // k[1] selects the lower row of the block, k[0] the right column.
  function automatic logic [RD_AW-1:0] src_addr(input logic [BH-1:0] br,
                                                input logic [BW-1:0] bc,
                                                input logic [1:0]    k);
    return RD_AW'(32'({br, k[1]}) * 32'(IMG_W) + 32'({bc, k[0]}));
  endfunction

  always_comb begin
    bcol_wrap = (bcol_q == BW'(IMG_W/2 - 1));
    last_blk  = bcol_wrap && (brow_q == BH'(IMG_H/2 - 1));
    bcol_d    = bcol_wrap ? '0 : bcol_q + 1'b1;
    brow_d    = bcol_wrap ? brow_q + 1'b1 : brow_q;
    sum_d     = sum_q + 10'(rd_data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      bcol_q    <= '0;
      brow_q    <= '0;
      sum_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            bcol_q    <= '0;
            brow_q    <= '0;
            sum_q     <= '0;
            k_q       <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= src_addr('0, '0, 2'd0);
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // rd_data_i carries the read issued in the previous cycle
          if (k_q != 2'd0) sum_q <= sum_d;
          if (k_q == 2'd3) begin
            rd_en_q <= 1'b0;
            k_q     <= '0;
            state_q <= S_LAST;
          end else begin
            k_q       <= k_q + 1'b1;
            rd_addr_q <= src_addr(brow_q, bcol_q, k_q + 1'b1);
          end
        end
        S_LAST: begin
          wr_data_q <= sum_d[9:2];
          wr_addr_q <= WR_AW'(32'(brow_q) * 32'(IMG_W/2) + 32'(bcol_q));
          sum_q     <= '0;
          wr_en_q   <= 1'b1;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ready_i) begin
            wr_en_q <= 1'b0;
            bcol_q  <= bcol_d;
            brow_q  <= brow_d;
            if (last_blk) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= src_addr(brow_d, bcol_d, 2'd0);
              k_q       <= '0;
              state_q   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
endmodule
